// File: rtl/result_display.sv
// Result display stage for the calculator ALU.
// Captures a 5-bit result with its op-select and flags, converts it to
// sign/tens/ones by repeated subtract-10, and scans a 3-digit common-anode
// 7-segment display (active-low segments and anodes).
// Optional build macro: BLANK_LEADING_ZERO_EN shows a blank tens digit when
// the tens value is zero. The default build always shows the tens digit.
//
// state | meaning
// IDLE  | after reset, display shows "---", load accepted
// CONV  | subtracting 10 per cycle from the magnitude, load ignored
// SHOW  | digits hold the last converted value or "Err", load accepted
module result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] result,
  input  logic [1:0] sel,
  input  logic       zeroFlag,
  input  logic       divByZeroFlag,
  output logic       ready,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       zeroLed,
  output logic       errLed
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  logic [1:0]    r_state;
  logic [4:0]    r_mag;
  logic [1:0]    r_tens;
  logic          r_sign;
  logic          r_zero_led;
  logic          r_err_led;
  logic [6:0]    r_dig0;
  logic [6:0]    r_dig1;
  logic [6:0]    r_dig2;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_scan;

  logic          w_neg;
  logic [4:0]    w_mag;
  logic [6:0]    w_tens_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Only subtraction results are signed; -16 maps to magnitude 16, which still fits 5 bits.
  assign w_neg = (sel == 2'b01) && result[4];
  assign w_mag = w_neg ? (~result + 5'd1) : result;

  // Tens digit pattern, optionally suppressing a leading zero.
`ifdef BLANK_LEADING_ZERO_EN
  assign w_tens_seg = (r_tens == 2'd0) ? SEG_BLANK : seg7({2'b00, r_tens});
`else
  assign w_tens_seg = seg7({2'b00, r_tens});
`endif

  // Capture, subtract-10 conversion and digit latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mag      <= 5'd0;
      r_tens     <= 2'd0;
      r_sign     <= 1'b0;
      r_zero_led <= 1'b0;
      r_err_led  <= 1'b0;
      r_dig0     <= SEG_DASH;
      r_dig1     <= SEG_DASH;
      r_dig2     <= SEG_DASH;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHOW: begin
          if (load) begin
            r_mag      <= w_mag;
            r_sign     <= w_neg;
            r_tens     <= 2'd0;
            r_zero_led <= zeroFlag;
            r_err_led  <= divByZeroFlag;
            if (divByZeroFlag) begin
              r_state <= ST_SHOW;
              r_dig2  <= SEG_E;
              r_dig1  <= SEG_R;
              r_dig0  <= SEG_R;
            end else begin
              r_state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (r_mag >= 5'd10) begin
            r_mag  <= r_mag - 5'd10;
            r_tens <= r_tens + 2'd1;
          end else begin
            r_dig2  <= r_sign ? SEG_DASH : SEG_BLANK;
            r_dig1  <= w_tens_seg;
            r_dig0  <= seg7(r_mag[3:0]);
            r_state <= ST_SHOW;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Free-running refresh counter advancing the active digit on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_scan <= 2'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_scan <= (r_scan == 2'd2) ? 2'd0 : r_scan + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Anode select and segment mux for the active digit.
  always_comb begin
    an  = 3'b110;
    seg = r_dig0;
    case (r_scan)
      2'd1: begin
        an  = 3'b101;
        seg = r_dig1;
      end
      2'd2: begin
        an  = 3'b011;
        seg = r_dig2;
      end
      default: begin
        an  = 3'b110;
        seg = r_dig0;
      end
    endcase
  end

  assign ready   = (r_state != ST_CONV);
  assign zeroLed = r_zero_led;
  assign errLed  = r_err_led;

endmodule

// File: tb/tb_result_display.sv
// Directed testbench for result_display with REFRESH_DIV=4.
module tb_result_display;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] result;
  logic [1:0] sel;
  logic       zeroFlag;
  logic       divByZeroFlag;
  logic       ready;
  logic [6:0] seg;
  logic [2:0] an;
  logic       zeroLed;
  logic       errLed;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_E     = 7'b0000110;
  localparam logic [6:0] S_R     = 7'b0101111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_9     = 7'b0010000;
`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] S_TENS0 = S_BLANK;
`else
  localparam logic [6:0] S_TENS0 = S_0;
`endif

  result_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .result(result), .sel(sel),
    .zeroFlag(zeroFlag), .divByZeroFlag(divByZeroFlag), .ready(ready),
    .seg(seg), .an(an), .zeroLed(zeroLed), .errLed(errLed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Wait (bounded) until the given anode is active, then check its segments.
  task automatic show_digit(input string tag, input logic [2:0] a, input logic [6:0] exp);
    int n = 0;
    while (an !== a && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, {5'd0, an}, {5'd0, a});
    chk(tag, {1'b0, seg}, {1'b0, exp});
  endtask

  task automatic do_load(input logic [4:0] r, input logic [1:0] s, input logic zf, input logic dz);
    load = 1'b1; result = r; sel = s; zeroFlag = zf; divByZeroFlag = dz;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [2:0] exp_an [4];

  initial begin
    exp_an = '{3'b110, 3'b101, 3'b011, 3'b110};
    rst_n = 1'b0; load = 1'b0; result = 5'd0; sel = 2'b00;
    zeroFlag = 1'b0; divByZeroFlag = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset values and free-running scan
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_an", {5'd0, an}, {5'd0, 3'b110});
    chk("rst_seg", {1'b0, seg}, {1'b0, S_DASH});
    chk("rst_zled", {7'd0, zeroLed}, 8'd0);
    chk("rst_eled", {7'd0, errLed}, 8'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("scan_an", {5'd0, an}, {5'd0, exp_an[k]});
      chk("scan_seg", {1'b0, seg}, {1'b0, S_DASH});
      chk("scan_ready", {7'd0, ready}, 8'd1);
      repeat (4) @(negedge clk);
    end

    // 2: 29 unsigned, three CONV cycles, old display held during CONV
    do_load(5'd29, 2'b10, 1'b0, 1'b0);
    chk("t2_rdy0", {7'd0, ready}, 8'd0);
    chk("t2_hold", {1'b0, seg}, {1'b0, S_DASH});
    @(negedge clk); chk("t2_rdy1", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t2_rdy2", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t2_rdy3", {7'd0, ready}, 8'd1);
    show_digit("t2_ones", 3'b110, S_9);
    show_digit("t2_tens", 3'b101, S_2);
    show_digit("t2_sign", 3'b011, S_BLANK);

    // 3: -3 via subtraction, one CONV cycle
    do_load(5'b11101, 2'b01, 1'b0, 1'b0);
    chk("t3_rdy0", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t3_rdy1", {7'd0, ready}, 8'd1);
    show_digit("t3_sign", 3'b011, S_DASH);
    show_digit("t3_ones", 3'b110, S_3);
    show_digit("t3_tens", 3'b101, S_TENS0);

    // 4: divide by zero shows Err without leaving ready
    do_load(5'd0, 2'b11, 1'b0, 1'b1);
    chk("t4_ready", {7'd0, ready}, 8'd1);
    chk("t4_eled", {7'd0, errLed}, 8'd1);
    show_digit("t4_e", 3'b011, S_E);
    show_digit("t4_r1", 3'b101, S_R);
    show_digit("t4_r0", 3'b110, S_R);
    // 4b: next clean load clears errLed, captures zeroLed, shows 0
    do_load(5'd0, 2'b00, 1'b1, 1'b0);
    chk("t4b_eled", {7'd0, errLed}, 8'd0);
    chk("t4b_zled", {7'd0, zeroLed}, 8'd1);
    @(negedge clk); chk("t4b_ready", {7'd0, ready}, 8'd1);
    show_digit("t4b_ones", 3'b110, S_0);
    show_digit("t4b_tens", 3'b101, S_TENS0);

    // 5: 31 with a second load during CONV that must be ignored
    load = 1'b1; result = 5'd31; sel = 2'b00; zeroFlag = 1'b0; divByZeroFlag = 1'b0;
    @(negedge clk);
    result = 5'd0; zeroFlag = 1'b1;
    chk("t5_rdy0", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t5_rdy1", {7'd0, ready}, 8'd0);
    load = 1'b0; zeroFlag = 1'b0;
    @(negedge clk); chk("t5_rdy2", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t5_rdy3", {7'd0, ready}, 8'd0);
    @(negedge clk); chk("t5_rdy4", {7'd0, ready}, 8'd1);
    chk("t5_zled", {7'd0, zeroLed}, 8'd0);
    show_digit("t5_ones", 3'b110, S_1);
    show_digit("t5_tens", 3'b101, S_3);
    show_digit("t5_sign", 3'b011, S_BLANK);

    // 6: reset mid-CONV discards conversion and display
    do_load(5'd25, 2'b00, 1'b1, 1'b0);
    chk("t6_rdy0", {7'd0, ready}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", {7'd0, ready}, 8'd1);
    chk("t6_an", {5'd0, an}, {5'd0, 3'b110});
    chk("t6_seg", {1'b0, seg}, {1'b0, S_DASH});
    chk("t6_zled", {7'd0, zeroLed}, 8'd0);
    chk("t6_eled", {7'd0, errLed}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ready_post", {7'd0, ready}, 8'd1);
    show_digit("t6_ones", 3'b110, S_DASH);
    show_digit("t6_tens", 3'b101, S_DASH);
    show_digit("t6_sign", 3'b011, S_DASH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
